mul_norm_round: RTL and testbench
=================================

# mul_norm_round

Pipelined normalise-and-round stage of the floating-point multiplier, placed directly after `mul_shift_num`. It takes the raw mantissa product, the pre-rounding biased exponent `expo_1`, the saturated `l_shift`/`r_shift` amounts, and the product's leading-zero count. It normalises the product, or denormalises it to the subnormal range, then rounds to nearest-even and packs the IEEE result with flags. It is two register stages deep with a valid/ready handshake at both ends.

## Interface

Parameters:
- `EXPO_W`, default 8: exponent field width.
- `MANT_W`, default 23: stored mantissa width.
- `ZERO_D`, default 6: shift-amount MSB index; shift ports are `ZERO_D+1` bits wide.

Ports (PW = 2*MANT_W+2):
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage can accept a beat.
- `sign` in 1: product sign.
- `expo_1` in EXPO_W+2: signed biased exponent of product bit PW-1.
- `mant_in` in PW: raw mantissa product.
- `lzc` in ZERO_D+1: leading zeros of `mant_in` (PW when the product is zero).
- `l_shift` in ZERO_D+1: saturated `expo_1-1`.
- `r_shift` in ZERO_D+1: saturated `1-expo_1`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `result` out EXPO_W+MANT_W+1: packed {sign, exponent, mantissa}.
- `overflow`, `underflow`, `inexact` out 1 each: IEEE flags.

## Operation

- Stage 1, normalise:
  - If `expo_1` is ≤ 0 (signed), right-shift `mant_in` by `r_shift`, zero-filled. OR every shifted-out bit into `sticky1`. Exponent is 0.
  - Otherwise left-shift by s = min(`lzc`, `l_shift`). Exponent is `expo_1`-s if bit PW-1 is set after the shift, else 0 (subnormal).
  - Shift amounts ≥ PW drive the in-window value to 0. All shifted-out bits still go to sticky.
- Stage 2, RNE rounding:
  - mant = bits [PW-1:PW-MANT_W-1]; guard = bit PW-MANT_W-2; sticky = OR(lower bits) | `sticky1`.
  - Round up when guard & (sticky | mant[0]).
  - Carry out of the top bit: exponent+1, mantissa >> 1.
  - A subnormal that rounds into bit PW-1 gets exponent 1.
- Overflow: exponent after rounding ≥ 2^EXPO_W-1, or `expo_1` ≥ 2^EXPO_W-1 on entry. Result is ±Inf; `overflow`=1 and `inexact`=1.
- `inexact` = guard | sticky, or overflow.
- `underflow` = result exponent 0 (pre-round tiny) & inexact.
- `mant_in` == 0: result is ±0, all flags 0.

## Timing

- Latency is 2 cycles from input handshake (`in_valid`&`in_ready`) to `out_valid`. Throughput is 1 beat per cycle.
- Each stage register loads when it is empty or its successor is loading/draining.
- `in_ready` = !s1_valid | s2 loadable. s2 is loadable when !s2_valid or `out_ready`.
- While `out_valid`&!`out_ready`:
  - `result`/flags hold stable.
  - No beat is dropped or duplicated; order is preserved.
  - At most 2 beats are buffered, after which `in_ready`=0.
- `in_ready` is combinational from `out_ready`. No other combinational in→out path.
- Reset values: both stage valids 0, `out_valid`=0, `result`=0, all flags 0. `in_ready`=1 after reset.
- Reset asserted mid-operation flushes both stages immediately, asynchronously. `out_valid` falls without waiting for a clock edge.
- Input data is ignored when `in_valid`=0. Data registers do not toggle on invalid cycles.

## Structure

- Package `mul_pkg`:
  - Localparam PW.
  - Struct `mul_s1_t` {sign, expo, mant[PW-1:0], sticky, zero, ovf}.
  - Function `rne_up(lsb, guard, sticky)`.
- Sub-module `mul_round_rne`: combinational stage-2 rounding, carry and exponent fix-up, Inf/zero packing, flags.
- The top level holds the shifter, both pipeline registers, and the handshake.

## Test plan

- Default params, `mant_in`=48'h8000_0000_0000, `expo_1`=127, `lzc`=0, `l_shift`=126, `r_shift`=47 → 2 cycles later `result`=32'h3F80_0000, flags 0.
- `mant_in`=bit47|bit24|bit23, `expo_1`=127 → tie with odd LSB → 32'h3F80_0002, `inexact`=1. Without bit24 → 32'h3F80_0000, `inexact`=1.
- `mant_in`=48'hFFFF_FFFF_FFFF, `expo_1`=127 → carry out → 32'h4000_0000, `inexact`=1.
- `mant_in`=bit47, `expo_1`=0, `r_shift`=1 → 32'h0040_0000, `underflow`=0. Same input with `expo_1`=255 → 32'h7F80_0000, `overflow`=1, `inexact`=1.
- 4 back-to-back beats with `out_ready`=0 for 5 cycles:
  - `in_ready` drops after 2 beats.
  - `result` holds stable.
  - After `out_ready`=1, all 4 beats emerge in order, no gaps.
- Both stages full, `rst_n` pulsed low between clock edges → `out_valid`=0 immediately. After release, `in_ready`=1 and no stale beat emerges.

Source files
------------

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types and helpers for the multiplier normalise/round pipeline.
//   PW        : raw mantissa product width (2*MANT_W+2) for the default format
//   mul_s1_t  : stage-1 payload handed from the normaliser to the rounder
//   rne_up()  : round-to-nearest-even increment decision
// The struct is sized for the default single-precision format
// (EXPO_W=8, MANT_W=23); the pipeline modules default to the same values.
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int DEF_EXPO_W = 8;
  localparam int DEF_MANT_W = 23;
  localparam int PW         = 2 * DEF_MANT_W + 2;
  localparam int S1_EXPO_W  = DEF_EXPO_W + 2;

  // Normalised product as seen between the two register stages.
  // expo is already 0 for subnormal results; ovf flags an exponent that
  // was out of range on entry and forces an Inf result downstream.
  typedef struct packed {
    logic                 sign;
    logic [S1_EXPO_W-1:0] expo;
    logic [PW-1:0]        mant;
    logic                 sticky;
    logic                 zero;
    logic                 ovf;
  } mul_s1_t;

  // Nearest-even: increment when above half, or exactly half with odd LSB.
  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/mul_round_rne.sv
// ---------------------------------------------------------------------------
// mul_round_rne
// Combinational rounding of a normalised product: RNE increment, mantissa
// carry-out fix-up, subnormal-to-normal promotion, Inf/zero packing and the
// IEEE overflow/underflow/inexact flags.
//   s1_i        : normalised product from stage 1
//   result_o    : packed {sign, exponent, mantissa}
//   overflow_o  : result saturated to +/-Inf
//   underflow_o : tiny before rounding and inexact
//   inexact_o   : any precision lost (or overflow)
// ---------------------------------------------------------------------------
module mul_round_rne
  import mul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  mul_s1_t                s1_i,
  output logic [EXPO_W+MANT_W:0] result_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic                   inexact_o
);

  localparam int                PROD_W   = 2 * MANT_W + 2;
  localparam logic [EXPO_W+1:0] EXPO_SAT = (EXPO_W+2)'((1 << EXPO_W) - 1);

  logic [MANT_W:0]   keptMant;
  logic              guardBit;
  logic              stickyBit;
  logic              roundUp;
  logic [MANT_W+1:0] roundedMant;
  logic              carryOut;
  logic [EXPO_W+1:0] roundedExpo;
  logic [MANT_W-1:0] fracOut;
  logic              ovfOut;
  logic              inexactOut;

  // keptMant includes the hidden bit at its MSB; everything below the guard
  // bit collapses into sticky together with what the shifter already lost.
  assign keptMant    = s1_i.mant[PROD_W-1 -: MANT_W+1];
  assign guardBit    = s1_i.mant[PROD_W-MANT_W-2];
  assign stickyBit   = (|s1_i.mant[PROD_W-MANT_W-3:0]) | s1_i.sticky;
  assign roundUp     = rne_up(keptMant[0], guardBit, stickyBit);
  assign roundedMant = {1'b0, keptMant} + {{(MANT_W+1){1'b0}}, roundUp};
  assign carryOut    = roundedMant[MANT_W+1];

  // A carry past the hidden bit bumps the exponent. A subnormal (expo 0)
  // whose increment reaches the hidden bit becomes the smallest normal.
  always_comb begin
    roundedExpo = s1_i.expo;
    if (carryOut) begin
      roundedExpo = s1_i.expo + (EXPO_W+2)'(1);
    end else if ((s1_i.expo == '0) && roundedMant[MANT_W]) begin
      roundedExpo = (EXPO_W+2)'(1);
    end
  end

  // After a carry the mantissa is 1.000..0, so shifting right drops a zero.
  assign fracOut    = carryOut ? roundedMant[MANT_W:1] : roundedMant[MANT_W-1:0];
  assign ovfOut     = s1_i.ovf || (roundedExpo >= EXPO_SAT);
  assign inexactOut = guardBit || stickyBit || ovfOut;

  // Zero wins over everything, then Inf, then the ordinary packed result.
  always_comb begin
    result_o    = {s1_i.sign, roundedExpo[EXPO_W-1:0], fracOut};
    overflow_o  = 1'b0;
    underflow_o = (s1_i.expo == '0) && inexactOut;
    inexact_o   = inexactOut;
    if (s1_i.zero) begin
      result_o    = {s1_i.sign, {(EXPO_W+MANT_W){1'b0}}};
      underflow_o = 1'b0;
      inexact_o   = 1'b0;
    end else if (ovfOut) begin
      result_o    = {s1_i.sign, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
      overflow_o  = 1'b1;
      underflow_o = 1'b0;
      inexact_o   = 1'b1;
    end
  end

endmodule

// File: rtl/mul_norm_round.sv
// ---------------------------------------------------------------------------
// mul_norm_round
// Two-stage normalise-and-round stage of the floating-point multiplier.
// Stage 1 shifts the raw product into normal (or subnormal) position and
// collects lost bits into sticky; stage 2 registers the RNE-rounded result.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream handshake
//   sign, expo_1         : product sign, signed biased exponent of bit PW-1
//   mant_in, lzc         : raw product and its leading-zero count
//   l_shift, r_shift     : saturated expo_1-1 and 1-expo_1
//   out_valid / out_ready: downstream handshake
//   result               : packed {sign, exponent, mantissa}
//   overflow, underflow, inexact : IEEE flags for result
// ---------------------------------------------------------------------------
module mul_norm_round
  import mul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int ZERO_D = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign,
  input  logic [EXPO_W+1:0]      expo_1,
  input  logic [2*MANT_W+1:0]    mant_in,
  input  logic [ZERO_D:0]        lzc,
  input  logic [ZERO_D:0]        l_shift,
  input  logic [ZERO_D:0]        r_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXPO_W+MANT_W:0] result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);

  localparam int                PROD_W      = 2 * MANT_W + 2;
  localparam logic [ZERO_D:0]   SHIFT_LIMIT = (ZERO_D+1)'(PROD_W);
  localparam logic [EXPO_W+1:0] EXPO_SAT    = (EXPO_W+2)'((1 << EXPO_W) - 1);

  logic                  expoNonPos;
  logic                  expoOvf;
  logic [ZERO_D:0]       leftAmt;
  logic [2*PROD_W-1:0]   rightWide;
  logic [2*PROD_W-1:0]   leftWide;
  logic [PROD_W-1:0]     normMant;
  logic                  normSticky;
  logic [EXPO_W+1:0]     normExpo;

  mul_s1_t               s1Data_d;
  mul_s1_t               s1Data_q;
  logic                  s1Valid_d;
  logic                  s1Valid_q;
  logic                  s2Valid_d;
  logic                  s2Valid_q;
  logic                  s1Load;
  logic                  s2Load;
  logic                  s2Take;

  logic [EXPO_W+MANT_W:0] rndResult;
  logic                   rndOvf;
  logic                   rndUnf;
  logic                   rndInx;
  logic [EXPO_W+MANT_W:0] result_q;
  logic                   overflow_q;
  logic                   underflow_q;
  logic                   inexact_q;

  assign expoNonPos = expo_1[EXPO_W+1] || (expo_1 == '0);
  assign expoOvf    = !expo_1[EXPO_W+1] && (expo_1 >= EXPO_SAT);

  // Never shift left further than the exponent allows; stopping early
  // leaves the hidden bit clear and produces a subnormal.
  assign leftAmt = (lzc < l_shift) ? lzc : l_shift;

  // Double-width shifts keep the bits leaving the window in the other half
  // so they can be ORed into sticky.
  assign rightWide = {mant_in, {PROD_W{1'b0}}} >> r_shift;
  assign leftWide  = {{PROD_W{1'b0}}, mant_in} << leftAmt;

  // Shift amounts of PW or more push the whole product out of the window.
  always_comb begin
    normMant   = '0;
    normSticky = 1'b0;
    normExpo   = '0;
    if (expoNonPos) begin
      if (r_shift >= SHIFT_LIMIT) begin
        normSticky = |mant_in;
      end else begin
        normMant   = rightWide[2*PROD_W-1:PROD_W];
        normSticky = |rightWide[PROD_W-1:0];
      end
    end else begin
      if (leftAmt >= SHIFT_LIMIT) begin
        normSticky = |mant_in;
      end else begin
        normMant   = leftWide[PROD_W-1:0];
        normSticky = |leftWide[2*PROD_W-1:PROD_W];
      end
      normExpo = normMant[PROD_W-1]
               ? (expo_1 - {{(EXPO_W+1-ZERO_D){1'b0}}, leftAmt})
               : '0;
    end
  end

  always_comb begin
    s1Data_d.sign   = sign;
    s1Data_d.expo   = normExpo;
    s1Data_d.mant   = normMant;
    s1Data_d.sticky = normSticky;
    s1Data_d.zero   = (mant_in == '0);
    s1Data_d.ovf    = expoOvf;
  end

  // A stage accepts a beat when it is empty or its contents move on in the
  // same cycle, which gives full throughput and at most two buffered beats.
  assign s2Load    = !s2Valid_q || out_ready;
  assign in_ready  = !s1Valid_q || s2Load;
  assign s1Load    = in_valid && in_ready;
  assign s2Take    = s1Valid_q && s2Load;
  assign s1Valid_d = in_ready ? in_valid : s1Valid_q;
  assign s2Valid_d = s2Load ? s1Valid_q : s2Valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s2Valid_q <= s2Valid_d;
    end
  end

  // Data registers only load on a real transfer so they stay quiet on idle
  // cycles and hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Data_q <= '0;
    end else if (s1Load) begin
      s1Data_q <= s1Data_d;
    end
  end

  mul_round_rne #(
    .EXPO_W (EXPO_W),
    .MANT_W (MANT_W)
  ) u_round (
    .s1_i        (s1Data_q),
    .result_o    (rndResult),
    .overflow_o  (rndOvf),
    .underflow_o (rndUnf),
    .inexact_o   (rndInx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else if (s2Take) begin
      result_q    <= rndResult;
      overflow_q  <= rndOvf;
      underflow_q <= rndUnf;
      inexact_q   <= rndInx;
    end
  end

  assign out_valid = s2Valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_mul_norm_round.sv
// ---------------------------------------------------------------------------
// tb_mul_norm_round
// Directed bench for mul_norm_round with default single-precision params.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [9:0]  expo_1 = '0;
  logic [47:0] mant_in = '0;
  logic [6:0]  lzc = '0;
  logic [6:0]  l_shift = '0;
  logic [6:0]  r_shift = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic               s;
    logic [47:0]        m;
    logic signed [31:0] e;
    logic [31:0]        res;
    logic [2:0]         fl;
  } vec_t;

  always #5 clk = ~clk;

  mul_norm_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .expo_1    (expo_1),
    .mant_in   (mant_in),
    .lzc       (lzc),
    .l_shift   (l_shift),
    .r_shift   (r_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  // Plays the upstream stage: derives lzc and the saturated shift amounts.
  task automatic applyStimulus(input logic s, input logic [47:0] m, input int e);
    int lz;
    int l;
    int r;
    lz = 48;
    for (int i = 0; i < 48; i++) if (m[i]) lz = 47 - i;
    l = e - 1;
    if (l < 0) l = 0;
    if (l > 127) l = 127;
    r = 1 - e;
    if (r < 0) r = 0;
    if (r > 127) r = 127;
    sign    = s;
    mant_in = m;
    expo_1  = 10'(e);
    lzc     = 7'(lz);
    l_shift = 7'(l);
    r_shift = 7'(r);
  endtask

  // One beat through an empty pipeline; lat counts edges from acceptance.
  task automatic runBeat(input logic s, input logic [47:0] m, input int e,
                         output logic [31:0] res, output logic [2:0] fl, output int lat);
    applyStimulus(s, m, e);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = result;
    fl  = {overflow, underflow, inexact};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] beatMant(input int k);
    return 48'h8000_0000_0000 | (48'(k + 1) << 24);
  endfunction

  task automatic test_reset();
    #3;
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    testsRun++;
    if (result !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_result: got %h expected 00000000", result);
    end
    testsRun++;
    if ({overflow, underflow, inexact} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {overflow, underflow, inexact});
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Garbage data with in_valid low must not produce a beat.
    applyStimulus(1'b1, 48'hDEAD_BEEF_1234, 100);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      testsRun++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL idle_no_beat[%0d]: out_valid=%b in_ready=%b expected 0 and 1", c, out_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_normalise();
    vec_t v[3];
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
    v[0] = '{1'b0, 48'h8000_0000_0000, 127, 32'h3F80_0000, 3'b000};
    v[1] = '{1'b0, 48'h4000_0000_0000, 128, 32'h3F80_0000, 3'b000};
    v[2] = '{1'b1, 48'hC000_0000_0000, 128, 32'hC040_0000, 3'b000};
    for (int i = 0; i < 3; i++) begin
      runBeat(v[i].s, v[i].m, v[i].e, res, fl, lat);
      testsRun++;
      if (res !== v[i].res || fl !== v[i].fl || lat != 2) begin
        testsFailed++;
        $display("[TB] FAIL normalise[%0d]: result=%h flags(ovf,unf,inx)=%b latency=%0d, expected %h %b 2",
                 i, res, fl, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t v[4];
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
    v[0] = '{1'b0, 48'h8000_0180_0000, 127, 32'h3F80_0002, 3'b001};
    v[1] = '{1'b0, 48'h8000_0080_0000, 127, 32'h3F80_0000, 3'b001};
    v[2] = '{1'b0, 48'hFFFF_FFFF_FFFF, 127, 32'h4000_0000, 3'b001};
    v[3] = '{1'b0, 48'h8000_0080_0001, 127, 32'h3F80_0001, 3'b001};
    for (int i = 0; i < 4; i++) begin
      runBeat(v[i].s, v[i].m, v[i].e, res, fl, lat);
      testsRun++;
      if (res !== v[i].res || fl !== v[i].fl || lat != 2) begin
        testsFailed++;
        $display("[TB] FAIL rounding[%0d]: result=%h flags(ovf,unf,inx)=%b latency=%0d, expected %h %b 2",
                 i, res, fl, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_subnormal();
    vec_t v[5];
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
    v[0] = '{1'b0, 48'h8000_0000_0000,    0, 32'h0040_0000, 3'b000};
    v[1] = '{1'b0, 48'h8000_0000_0001,    0, 32'h0040_0000, 3'b011};
    v[2] = '{1'b0, 48'hFFFF_FFFF_FFFF,    0, 32'h0080_0000, 3'b011};
    v[3] = '{1'b0, 48'h4000_0000_0000,    1, 32'h0040_0000, 3'b000};
    v[4] = '{1'b1, 48'h8000_0000_0000, -100, 32'h8000_0000, 3'b011};
    for (int i = 0; i < 5; i++) begin
      runBeat(v[i].s, v[i].m, v[i].e, res, fl, lat);
      testsRun++;
      if (res !== v[i].res || fl !== v[i].fl || lat != 2) begin
        testsFailed++;
        $display("[TB] FAIL subnormal[%0d]: result=%h flags(ovf,unf,inx)=%b latency=%0d, expected %h %b 2",
                 i, res, fl, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[4];
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
    v[0] = '{1'b0, 48'h8000_0000_0000, 255, 32'h7F80_0000, 3'b101};
    v[1] = '{1'b1, 48'h8000_0000_0000, 300, 32'hFF80_0000, 3'b101};
    v[2] = '{1'b0, 48'hFFFF_FFFF_FFFF, 254, 32'h7F80_0000, 3'b101};
    v[3] = '{1'b0, 48'h8000_0000_0000, 254, 32'h7F00_0000, 3'b000};
    for (int i = 0; i < 4; i++) begin
      runBeat(v[i].s, v[i].m, v[i].e, res, fl, lat);
      testsRun++;
      if (res !== v[i].res || fl !== v[i].fl || lat != 2) begin
        testsFailed++;
        $display("[TB] FAIL overflow[%0d]: result=%h flags(ovf,unf,inx)=%b latency=%0d, expected %h %b 2",
                 i, res, fl, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_zero();
    vec_t v[3];
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
    v[0] = '{1'b0, 48'h0, 127, 32'h0000_0000, 3'b000};
    v[1] = '{1'b1, 48'h0, 300, 32'h8000_0000, 3'b000};
    v[2] = '{1'b0, 48'h0, -20, 32'h0000_0000, 3'b000};
    for (int i = 0; i < 3; i++) begin
      runBeat(v[i].s, v[i].m, v[i].e, res, fl, lat);
      testsRun++;
      if (res !== v[i].res || fl !== v[i].fl || lat != 2) begin
        testsFailed++;
        $display("[TB] FAIL zero[%0d]: result=%h flags(ovf,unf,inx)=%b latency=%0d, expected %h %b 2",
                 i, res, fl, lat, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    logic rdy = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, beatMant(0), 127);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rdy = in_ready;
      if (c >= 2) begin
        testsRun++;
        if (out_valid !== 1'b1 || result !== 32'h3F80_0001) begin
          testsFailed++;
          $display("[TB] FAIL stall_hold[%0d]: out_valid=%b result=%h expected 1 3f800001", c, out_valid, result);
        end
      end
      @(posedge clk);
      if (rdy && in_valid) sent++;
      #1;
      if (sent < 4) applyStimulus(1'b0, beatMant(sent), 127);
      in_valid = (sent < 4);
    end
    testsRun++;
    if (sent != 2 || rdy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stall_fill: accepted=%0d in_ready=%b expected 2 and 0", sent, rdy);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      @(negedge clk);
      rdy = in_ready;
      if (out_valid) begin
        testsRun++;
        if (result !== 32'h3F80_0000 + 32'(got + 1) || c != got) begin
          testsFailed++;
          $display("[TB] FAIL drain_order[%0d]: result=%h at cycle %0d, expected %h at cycle %0d",
                   got, result, c, 32'h3F80_0000 + 32'(got + 1), got);
        end
        got++;
      end
      @(posedge clk);
      if (rdy && in_valid) sent++;
      #1;
      if (sent < 4) applyStimulus(1'b0, beatMant(sent), 127);
      in_valid = (sent < 4);
    end
    testsRun++;
    if (got != 4 || sent != 4) begin
      testsFailed++;
      $display("[TB] FAIL drain_count: received=%0d accepted=%0d expected 4 and 4", got, sent);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic sawValid = 1'b0;
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
    out_ready = 1'b0;
    applyStimulus(1'b0, beatMant(9), 127);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, beatMant(10), 127);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    testsRun++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_prefill: out_valid=%b in_ready=%b expected 1 and 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL rst_async_flush: out_valid=%b in_ready=%b result=%h expected 0 1 00000000",
               out_valid, in_ready, result);
    end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    testsRun++;
    if (sawValid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_no_stale: saw out_valid=%b in_ready=%b expected 0 and 1", sawValid, in_ready);
    end
    @(posedge clk);
    #1;
    runBeat(1'b0, 48'h8000_0000_0000, 127, res, fl, lat);
    testsRun++;
    if (res !== 32'h3F80_0000 || fl !== 3'b000 || lat != 2) begin
      testsFailed++;
      $display("[TB] FAIL rst_recover: result=%h flags=%b latency=%0d expected 3f800000 000 2", res, fl, lat);
    end
  endtask

  initial begin
    test_reset();
    test_normalise();
    test_rounding();
    test_subnormal();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
